// File: rtl/std_core_rfifo_pkg.sv
// -----------------------------------------------------------------------------
// std_core_rfifo_pkg
//   Shared types for the ready/valid FIFO. This package holds the per-cycle
//   operation encoding that the pointer/count control decodes.
//   It has no ports; it only provides types.
// -----------------------------------------------------------------------------
package std_core_rfifo_pkg;

  // Per-edge FIFO operation, packed as {push, pop}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : std_core_rfifo_pkg

// File: rtl/std_core_rfifo_ram.sv
// -----------------------------------------------------------------------------
// std_core_rfifo_ram
//   DEPTH x DW storage array with one write port and one read port.
//   Writes happen on the clock edge. Reads are combinational.
//   The array is not reset, because its contents are only observed through
//   valid pointers.
// Ports
//   clk    in  1   rising-edge clock
//   we     in  1   write enable
//   waddr  in  AW  write address
//   wdata  in  DW  write data
//   raddr  in  AW  read address
//   rdata  out DW  read data (asynchronous)
// -----------------------------------------------------------------------------
module std_core_rfifo_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule : std_core_rfifo_ram

// File: rtl/std_core_rfifo.sv
// -----------------------------------------------------------------------------
// std_core_rfifo
//   Synchronous ready/valid FIFO with first-word-fall-through output.
//   The head entry is presented combinationally from storage.
//   All outputs are functions of registered state, except that p_rdy is also
//   gated by rst.
//   There is no bypass path: a word pushed at edge k becomes visible right
//   after edge k.
//   A full FIFO never accepts a push, even when a pop happens in the same
//   cycle.
// Ports
//   clk    in  1   rising-edge clock
//   rst    in  1   synchronous active-high reset
//   p      in  DW  producer data
//   p_val  in  1   producer valid
//   p_rdy  out 1   FIFO can accept (not full, not in reset)
//   c      out DW  head entry (zero when empty)
//   c_val  out 1   head entry valid
//   c_rdy  in  1   consumer ready
// -----------------------------------------------------------------------------
module std_core_rfifo
  import std_core_rfifo_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] p,
  input  logic          p_val,
  output logic          p_rdy,
  output logic [DW-1:0] c,
  output logic          c_val,
  input  logic          c_rdy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q,    cnt_d;

  logic          push_s;
  logic          pop_s;
  logic [DW-1:0] rdata_s;
  fifo_op_e      op_s;

  assign p_rdy  = !rst && (cnt_q != CNT_FULL);
  assign c_val  = (cnt_q != CNT_ZERO);
  assign c      = c_val ? rdata_s : {DW{1'b0}};

  assign push_s = p_val && p_rdy;
  assign pop_s  = c_val && c_rdy;
  assign op_s   = fifo_op_e'({push_s, pop_s});

  std_core_rfifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_q),
    .wdata (p),
    .raddr (rd_ptr_q),
    .rdata (rdata_s)
  );

  // Next pointer/count values. Pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    case (op_s)
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        cnt_d    = cnt_q + CNT_ONE;
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        cnt_d    = cnt_q - CNT_ONE;
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      OP_NONE: begin
        cnt_d    = cnt_q;
      end
      default: begin
        cnt_d    = cnt_q;
      end
    endcase
  end

  // Pointer/count state. Reset discards every stored entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      cnt_q    <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule : std_core_rfifo

// File: tb/tb_std_core_rfifo.sv
// -----------------------------------------------------------------------------
// tb_std_core_rfifo
//   Self-checking bench for std_core_rfifo with two instances.
//   Instance A (DEPTH=256) runs the directed reset, single-word, full,
//   concurrent and mid-stream reset scenarios.
//   Instance B (DEPTH=16) runs a long randomized stream.
//   Expected outputs come from a queue model of the FIFO rules.
// -----------------------------------------------------------------------------
module tb_std_core_rfifo;

  localparam int DW = 16;
  localparam int DA = 256;
  localparam int DB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, p_val_a, p_rdy_a, c_val_a, c_rdy_a;
  logic [DW-1:0] p_a, c_a;
  logic          rst_b, p_val_b, p_rdy_b, c_val_b, c_rdy_b;
  logic [DW-1:0] p_b, c_b;

  std_core_rfifo #(.DW(DW), .DEPTH(DA)) u_dut_a (
    .clk(clk), .rst(rst_a), .p(p_a), .p_val(p_val_a), .p_rdy(p_rdy_a),
    .c(c_a), .c_val(c_val_a), .c_rdy(c_rdy_a)
  );

  std_core_rfifo #(.DW(DW), .DEPTH(DB)) u_dut_b (
    .clk(clk), .rst(rst_b), .p(p_b), .p_val(p_val_b), .p_rdy(p_rdy_b),
    .c(c_b), .c_val(c_val_b), .c_rdy(c_rdy_b)
  );

  int n_checks = 0;
  int n_errs   = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle on instance A. The task starts at a negedge, checks the outputs,
  // lets the edge happen, updates the model, and ends at the next negedge.
  task automatic cyc_a(input logic r, input logic pv, input logic [DW-1:0] d, input logic cr);
    logic push, pop;
    rst_a = r; p_val_a = pv; p_a = d; c_rdy_a = cr;
    #1;
    check("a_p_rdy", p_rdy_a, !r && (qa.size() < DA));
    check("a_c_val", c_val_a, qa.size() != 0);
    check("a_c", c_a, (qa.size() != 0) ? qa[0] : 16'h0000);
    push = !r && pv && (qa.size() < DA);
    pop  = !r && cr && (qa.size() != 0);
    @(posedge clk);
    if (r) begin
      qa.delete();
    end else begin
      if (pop)  void'(qa.pop_front());
      if (push) qa.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic r, input logic pv, input logic [DW-1:0] d, input logic cr,
                       output logic pushed, output logic popped);
    logic push, pop;
    rst_b = r; p_val_b = pv; p_b = d; c_rdy_b = cr;
    #1;
    check("b_p_rdy", p_rdy_b, !r && (qb.size() < DB));
    check("b_c_val", c_val_b, qb.size() != 0);
    check("b_c", c_b, (qb.size() != 0) ? qb[0] : 16'h0000);
    push = !r && pv && (qb.size() < DB);
    pop  = !r && cr && (qb.size() != 0);
    @(posedge clk);
    if (r) begin
      qb.delete();
    end else begin
      if (pop)  void'(qb.pop_front());
      if (push) qb.push_back(d);
    end
    @(negedge clk);
    pushed = push;
    popped = pop;
  endtask

  // Drains A with c_rdy=1 and p_val=0, and returns how many pops the DUT showed.
  task automatic drain_a(output int n);
    n = 0;
    while (c_val_a === 1'b1 && n < 1000) begin
      cyc_a(1'b0, 1'b0, 16'h0000, 1'b1);
      n++;
    end
  endtask

  initial begin
    int n;
    int pops_b, pushes_b, cycles_b;
    logic pu, po, dummy_pu, dummy_po;

    rst_a = 1'b1; p_val_a = 1'b0; p_a = '0; c_rdy_a = 1'b0;
    rst_b = 1'b1; p_val_b = 1'b0; p_b = '0; c_rdy_b = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // 1: reset held two cycles with p_val=1, then release
    cyc_a(1'b1, 1'b1, 16'hBEEF, 1'b0);
    cyc_a(1'b1, 1'b1, 16'hBEEF, 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    check("rst_c_val_release", c_val_a, 1'b0);

    // 2: single word, held for two cycles, popped at k+3
    cyc_a(1'b0, 1'b1, 16'h00A5, 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b1);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);

    // 3: fill to full, offer 0x1234 while full, then drain
    for (int i = 0; i < DA; i++) cyc_a(1'b0, 1'b1, DW'(i), 1'b0);
    check("full_p_rdy", p_rdy_a, 1'b0);
    for (int i = 0; i < 3; i++) cyc_a(1'b0, 1'b1, 16'h1234, 1'b0);
    cyc_a(1'b0, 1'b1, 16'h1234, 1'b1);
    check("p_rdy_after_pop", p_rdy_a, 1'b1);
    cyc_a(1'b0, 1'b1, 16'h1234, 1'b1);
    drain_a(n);
    check("full_drain_len", n, 32'd255);

    // 4: hold the count at 5 with simultaneous push and pop
    for (int i = 0; i < 5; i++) cyc_a(1'b0, 1'b1, DW'(16'h0100 + i), 1'b0);
    for (int i = 0; i < 100; i++) cyc_a(1'b0, 1'b1, DW'(16'h0200 + i), 1'b1);
    drain_a(n);
    check("conc_count", n, 32'd5);

    // 6: reset in mid-stream with 100 entries held
    for (int i = 0; i < 100; i++) cyc_a(1'b0, 1'b1, DW'(16'h0300 + i), 1'b0);
    cyc_a(1'b1, 1'b0, 16'h0000, 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc_a(1'b0, 1'b1, 16'h0042, 1'b0);
    drain_a(n);
    check("rst_mid_alone", n, 32'd1);

    // 5: randomized stream on instance B
    cyc_b(1'b1, 1'b0, 16'h0000, 1'b0, dummy_pu, dummy_po);
    pops_b = 0; pushes_b = 0; cycles_b = 0;
    while (pops_b < 10000 && cycles_b < 40000) begin
      cyc_b(1'b0, ($urandom_range(0, 99) < 70), DW'($urandom), ($urandom_range(0, 99) < 70), pu, po);
      if (pu) pushes_b++;
      if (po) pops_b++;
      cycles_b++;
    end
    check("rand_xfers", pops_b >= 10000, 1'b1);
    check("rand_wraps", (pushes_b / DB) >= 600, 1'b1);
    n = qb.size();
    cycles_b = 0;
    while (c_val_b === 1'b1 && cycles_b < 100) begin
      cyc_b(1'b0, 1'b0, 16'h0000, 1'b1, dummy_pu, dummy_po);
      cycles_b++;
    end
    check("rand_drain_len", cycles_b, n);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule : tb_std_core_rfifo
